mm_responder: RTL and testbench

MM_RESPONDER -- requirements
Module: mm_responder

---
 rtl/mm_pkg.sv | 18 +
 rtl/mm_array.sv | 24 ++
 rtl/mm_responder.sv | 102 ++++++++++
 tb/tb_mm_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and defaults for the main-memory responder.
// Holds the FSM state encoding and default bus geometry.
package mm_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int ADDR_W_DEF  = 8;
   localparam int LATENCY_DEF = 3;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      SWP_WB,
      SWP_RD,
      DONE
   } mmState_e;

endpackage

// File: rtl/mm_array.sv
// Backing store for the responder: one shared address port,
// synchronous write and combinational read.
module mm_array
   import mm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mm_responder.sv
// Main-memory responder for a cache: read fill, write, and
// swap (victim write-back then fill), each phase LATENCY cycles.
module mm_responder
   import mm_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mm_read,
   input  logic              mm_write,
   input  logic              cache_swap,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] old_tag,
   input  logic [DATA_W-1:0] cache_to_mem,
   output logic [DATA_W-1:0] mem_to_cache,
   output logic              ready,
   output logic              busy
);

   localparam logic [3:0] LOAD = 4'(LATENCY - 1);

   mmState_e          state, nextState;
   logic [3:0]        count, nextCount;
   logic [ADDR_W-1:0] addrQ, oldTagQ;
   logic [DATA_W-1:0] dataQ;
   logic              lastCycle, memWe, fillLoad;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memRdata;

   always_comb begin
      nextState = state;
      nextCount = (count != 4'd0) ? count - 4'd1 : count;
      lastCycle = (count == 4'd0);
      unique case (state)
         IDLE: begin
            // swap outranks write; read+write without swap is a write
            if (mm_read && cache_swap) begin
               nextState = SWP_WB;
               nextCount = LOAD;
            end else if (mm_write) begin
               nextState = WR;
               nextCount = LOAD;
            end else if (mm_read) begin
               nextState = RD;
               nextCount = LOAD;
            end
         end
         WR, RD, SWP_RD: begin
            if (lastCycle) nextState = DONE;
         end
         SWP_WB: begin
            if (lastCycle) begin
               nextState = SWP_RD;
               nextCount = LOAD;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign memWe    = lastCycle && (state == WR || state == SWP_WB);
   assign fillLoad = lastCycle && (state == RD || state == SWP_RD);
   assign memAddr  = (state == SWP_WB) ? oldTagQ : addrQ;
   assign ready    = (state == DONE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= 4'd0;
         mem_to_cache <= '0;
         addrQ        <= '0;
         oldTagQ      <= '0;
         dataQ        <= '0;
      end else begin
         state <= nextState;
         count <= nextCount;
         if (state == IDLE) begin
            addrQ   <= addr;
            oldTagQ <= old_tag;
            dataQ   <= cache_to_mem;
         end
         if (fillLoad) mem_to_cache <= memRdata;
      end
   end

   mm_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) uArray (
      .clk  (clk),
      .we   (memWe),
      .addr (memAddr),
      .wdata(dataQ),
      .rdata(memRdata)
   );

endmodule

// File: tb/tb_mm_responder.sv
// Scoreboard bench for mm_responder: directed scenarios then
// random traffic against an array-level reference model.
module tb_mm_responder;

   localparam int L = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       mm_read, mm_write, cache_swap;
   logic [7:0] addr, old_tag, cache_to_mem;
   logic [7:0] mem_to_cache;
   logic       ready, busy;

   typedef struct {
      logic [7:0] data;
      int         acc;
      int         lat;
      string      name;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] refMem [256];
   logic [7:0] refFill;
   int         cycle = 0;
   int         checks = 0;
   int         passes = 0;
   logic       prevReady = 1'b0;

   mm_responder #(
      .DATA_W (8),
      .ADDR_W (8),
      .LATENCY(L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mm_read     (mm_read),
      .mm_write    (mm_write),
      .cache_swap  (cache_swap),
      .addr        (addr),
      .old_tag     (old_tag),
      .cache_to_mem(cache_to_mem),
      .mem_to_cache(mem_to_cache),
      .ready       (ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %0h want %0h", nm, got, want);
   endtask

   // Latency = cycles from the accepting edge through the ready cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevReady = 1'b0;
         end else begin
            if (ready) begin
               chk("readyWidth", 32'(prevReady), 0);
               chk("busyAtReady", 32'(busy), 1);
               if (sb.size() == 0) begin
                  chk("unexpectedReady", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk({e.name, " data"}, 32'(mem_to_cache), 32'(e.data));
                  chk({e.name, " latency"}, 32'(cycle - e.acc + 1),
                      32'(e.lat));
               end
            end
            prevReady = ready;
         end
      end
   end

   task automatic issue(input string nm, input bit r, input bit w,
                        input bit s, input logic [7:0] a,
                        input logic [7:0] o, input logic [7:0] d,
                        input bit track);
      int   n = 0;
      exp_t e;
      bit   acc;
      while ((busy || ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk({nm, " idleTimeout"}, 1, 0);
      mm_read      = r;
      mm_write     = w;
      cache_swap   = s;
      addr         = a;
      old_tag      = o;
      cache_to_mem = d;
      acc = (r && s) || w || r;
      if (track && acc) begin
         if (r && s) begin
            refMem[o] = d;
            refFill   = refMem[a];
            e.lat     = 2 * L + 1;
         end else if (w) begin
            refMem[a] = d;
            e.lat     = L + 1;
         end else begin
            refFill = refMem[a];
            e.lat   = L + 1;
         end
         e.data = refFill;
         e.acc  = cycle + 1;
         e.name = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      mm_read    = 1'b0;
      mm_write   = 1'b0;
      cache_swap = 1'b0;
      addr       = 8'h00;
      old_tag    = 8'h00;
      chk({nm, " busy"}, 32'(busy), 32'(acc));
   endtask

   function automatic logic [7:0] rndAddr();
      if ($urandom_range(0, 7) == 0) return 8'hFF;
      return 8'($urandom_range(0, 15));
   endfunction

   initial begin
      int n;
      rst = 1'b1;
      mm_read = 1'b0;
      mm_write = 1'b0;
      cache_swap = 1'b0;
      addr = '0;
      old_tag = '0;
      cache_to_mem = '0;
      refFill = '0;
      foreach (refMem[i]) refMem[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rstData", 32'(mem_to_cache), 0);
      chk("rstReady", 32'(ready), 0);
      chk("rstBusy", 32'(busy), 0);
      rst = 1'b0;

      issue("wr10", 0, 1, 0, 8'h10, 8'h00, 8'h5A, 1);
      issue("rd10", 1, 0, 0, 8'h10, 8'h00, 8'h00, 1);
      issue("wr20", 0, 1, 0, 8'h20, 8'h00, 8'h11, 1);
      issue("swap20", 1, 0, 1, 8'h20, 8'h30, 8'hC3, 1);
      issue("rd30", 1, 0, 0, 8'h30, 8'h00, 8'h00, 1);
      issue("swapFF", 1, 0, 1, 8'hFF, 8'hFF, 8'h77, 1);
      issue("rw05", 1, 1, 0, 8'h05, 8'h00, 8'hAB, 1);
      issue("rd05", 1, 0, 0, 8'h05, 8'h00, 8'h00, 1);
      issue("swapOnly", 0, 0, 1, 8'h10, 8'h20, 8'hEE, 1);
      repeat (6) @(negedge clk);

      issue("rdBusyDrop", 1, 0, 0, 8'h10, 8'h00, 8'h00, 1);
      mm_read = 1'b1;
      addr    = 8'h30;
      @(negedge clk);
      mm_read = 1'b0;
      addr    = 8'h00;

      issue("wr40abort", 0, 1, 0, 8'h40, 8'h00, 8'h99, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midRstData", 32'(mem_to_cache), 0);
      chk("midRstReady", 32'(ready), 0);
      chk("midRstBusy", 32'(busy), 0);
      refFill = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      issue("rd40", 1, 0, 0, 8'h40, 8'h00, 8'h00, 1);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: issue("rndRd", 1, 0, 0, rndAddr(), 8'h00,
                           8'h00, 1);
            3, 4, 5: issue("rndWr", 0, 1, 0, rndAddr(), 8'h00,
                           8'($urandom), 1);
            6, 7:    issue("rndSwap", 1, 0, 1, rndAddr(), rndAddr(),
                           8'($urandom), 1);
            8:       issue("rndRw", 1, 1, 0, rndAddr(), 8'h00,
                           8'($urandom), 1);
            default: issue("rndSwapOnly", 0, 0, 1, rndAddr(),
                           rndAddr(), 8'($urandom), 1);
         endcase
      end

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboardDrained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
